// File: rtl/button_debounce.sv
// Button debouncer: two-flop synchronizer, four-state debounce FSM, press/release strobes.
// Optional long-press strobe is built only when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
module button_debounce #(
  parameter int CLK_HZ      = 27000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [1:0] dbg_state_o
);

  localparam int DB_CYCLES   = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int LONG_CYCLES = (CLK_HZ / 1000) * LONG_MS;
  localparam int DB_W        = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic [1:0]      sync_q;
  logic            sync_pressed;
  state_e          state_q;
  logic [DB_W-1:0] db_cnt_q;
  logic            level_q;
  logic            press_q;
  logic            release_q;

  // Reset value 1 means "released" so reset never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], btn_n};
    end
  end

  assign sync_pressed = ~sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RELEASED;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (sync_pressed) begin
            state_q  <= PRESS_WAIT;
            db_cnt_q <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync_pressed) begin
            state_q  <= RELEASED;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_q  <= PRESSED;
            db_cnt_q <= '0;
            level_q  <= 1'b1;
            press_q  <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync_pressed) begin
            state_q  <= RELEASE_WAIT;
            db_cnt_q <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back to pressed resumes the same press silently.
          if (sync_pressed) begin
            state_q  <= PRESSED;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_q   <= RELEASED;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= RELEASED;
          db_cnt_q <= '0;
          level_q  <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign dbg_state_o   = state_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int LONG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] hold_q;
  logic              long_done_q;
  logic              long_q;

  // Hold time accumulates only in PRESSED; release bounces freeze it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q      <= '0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (state_q == PRESS_WAIT && sync_pressed && db_cnt_q == DB_LAST) begin
        hold_q      <= '0;
        long_done_q <= 1'b0;
      end else if (state_q == PRESSED) begin
        if (hold_q == LONG_LAST) begin
          if (!long_done_q) begin
            long_q      <= 1'b1;
            long_done_q <= 1'b1;
          end
        end else begin
          hold_q <= hold_q + 1'b1;
        end
      end
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = 1'b0;
`endif

  a_no_dual_strobe: assert property (@(posedge clk) disable iff (!rst)
    !(press_pulse && release_pulse));

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DB_CYCLES=4, LONG_CYCLES=10.
module tb_button_debounce;

  localparam int CLK_HZ      = 1000;
  localparam int DEBOUNCE_MS = 4;
  localparam int LONG_MS     = 10;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_n = 1'b1;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [1:0] dbg_state;

  typedef struct {
    logic btn_n;
    logic lvl;
    logic prs;
    logic rel;
    logic lng;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  button_debounce #(
    .CLK_HZ(CLK_HZ),
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .LONG_MS(LONG_MS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_n(btn_n),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0b expected %0b", name, idx, act, exp);
    end
  endtask

  function automatic void add(input logic b, input logic l, input logic p,
                              input logic r, input logic g);
    vec_t v;
    v.btn_n = b;
    v.lvl   = l;
    v.prs   = p;
    v.rel   = r;
    v.lng   = g;
    vecs.push_back(v);
  endfunction

  task automatic check_all(input string name, input int idx, input logic l,
                           input logic p, input logic r, input logic g);
    check({name, "_level"},   idx, btn_level,     l);
    check({name, "_press"},   idx, press_pulse,   p);
    check({name, "_release"}, idx, release_pulse, r);
    check({name, "_long"},    idx, long_pulse,    g);
  endtask

  initial begin
    // Step i: btn_n is sampled at edge i, outputs checked after edge i.
    // Clean press: low steps 2..21.
    for (int i = 0; i < 34; i++)
      add(!(i >= 2 && i <= 21), i >= 8 && i <= 27, i == 8, i == 28, LONG_EN && i == 18);
    // Press bounce: low 3, high 1, then low steady from step 6.
    for (int i = 0; i < 26; i++)
      add(!((i >= 2 && i <= 4) || (i >= 6 && i <= 15)), i >= 12 && i <= 21,
          i == 12, i == 22, 1'b0);
    // Release glitch: high at steps 14,15 while pressed; hold counter freezes two cycles.
    for (int i = 0; i < 36; i++)
      add(!((i >= 2 && i <= 13) || (i >= 16 && i <= 25)), i >= 8 && i <= 31,
          i == 8, i == 32, LONG_EN && i == 20);
    // Long press: low for 30 cycles.
    for (int i = 0; i < 42; i++)
      add(!(i >= 2 && i <= 31), i >= 8 && i <= 37, i == 8, i == 38, LONG_EN && i == 18);

    // Reset state.
    repeat (3) @(negedge clk);
    check_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      btn_n = vecs[i].btn_n;
      @(posedge clk);
      @(negedge clk);
      check_all("vec", i, vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].lng);
    end

    // Reset while PRESSED: level drops at once, no strobe afterwards.
    btn_n = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_reset_level", 0, btn_level, 1'b1);
    #2 rst = 1'b0;
    #1 check_all("rst_pressed", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    btn_n = 1'b1;
    for (int n = 1; n <= 2; n++) begin
      @(negedge clk);
      check_all("rst_pressed_hold", n, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      check_all("after_rst_pressed", n, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset in PRESS_WAIT with btn_n held low, then full latency after release.
    btn_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_all("rst_presswait", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 2; n++) begin
      @(negedge clk);
      check_all("rst_presswait_hold", n, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    // Edge 1 is the first post-reset sampling edge, so the press lands after edge 7.
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk);
      @(negedge clk);
      check("post_rst_press", n, press_pulse, n == 7);
      check("post_rst_level", n, btn_level, n >= 7);
    end
    btn_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      check("post_rst_release", n, release_pulse, n == 7);
      check("post_rst_rel_level", n, btn_level, n < 7);
      check("post_rst_long", n, long_pulse, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
